// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB LED arbiter: FSM encoding, colour field
// offsets and the mapping of LED/channel pairs onto dout bits.
package rgb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHOW  = 2'd2,
        ST_BLANK = 2'd3
    } state_e;

    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    localparam int LED0 = 0;
    localparam int LED1 = 1;
    localparam int N_LED = 2;

    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;
    localparam int N_CH = 3;

    // dout = {LED1 B,G,R, LED0 B,G,R}
    function automatic int dout_idx(input int led, input int ch);
        return led * N_CH + ch;
    endfunction

    function automatic int ch_lsb(input int ch);
        case (ch)
            CH_R:    return R_LSB;
            CH_G:    return G_LSB;
            default: return B_LSB;
        endcase
    endfunction

endpackage

// File: rtl/rgb_pwm_out.sv
// Six-channel PWM stage: free-running counter and registered duty compares.
module rgb_pwm_out
    import rgb_pkg::*;
#(
    parameter int PWM_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [5:0][PWM_WIDTH-1:0]  duty,
    output logic [5:0]                 dout
);

    logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [5:0]           dout_q, dout_d;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_WIDTH'(1);
        dout_d    = '0;
        for (int k = 0; k < N_LED * N_CH; k++) begin
            dout_d[k] = duty[k] > pwm_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= '0;
            dout_q    <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            dout_q    <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/rgb_led_arbiter.sv
// Round-robin owner of the two RGB LEDs with a fixed dwell per grant; the winner's
// colour is latched at grant time, brightness-capped, masked per LED and sent to PWM.
module rgb_led_arbiter
    import rgb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int PWM_WIDTH    = 8,
    parameter int BRIGHT_CAP   = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*24-1:0]  color,
    input  logic [N_REQ*2-1:0]   led_sel,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic [5:0]           dout
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DW_W  = $clog2(DWELL_CYCLES);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]            win_q, win_d;
    logic [IDX_W-1:0]            pick_idx;
    logic [DW_W-1:0]             dwell_cnt_q, dwell_cnt_d;
    logic [N_REQ-1:0]            grant_q, grant_d;
    logic [5:0][PWM_WIDTH-1:0]   duty_q, duty_d, load_duty, pwm_duty;
    logic [23:0]                 win_color;
    logic [1:0]                  win_sel;
    logic                        owner_req;

    function automatic logic [PWM_WIDTH-1:0] cap(input logic [7:0] field);
        int v;
        v = int'(field);
        if (v > BRIGHT_CAP) v = BRIGHT_CAP;
        return PWM_WIDTH'(v);
    endfunction

    assign win_color = color[int'(win_q) * 24 +: 24];
    assign win_sel   = led_sel[int'(win_q) * 2 +: 2];
    assign owner_req = |(req & grant_q);

    // First set request at or after rr_ptr, wrapping past the last index.
    always_comb begin
        logic found;
        int   idx;
        found    = 1'b0;
        idx      = 0;
        pick_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                pick_idx = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        load_duty = '0;
        for (int led = LED0; led <= LED1; led++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (win_sel[led]) begin
                    load_duty[dout_idx(led, ch)] = cap(win_color[ch_lsb(ch) +: 8]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            dwell_cnt_q <= '0;
            grant_q     <= '0;
            duty_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            dwell_cnt_q <= dwell_cnt_d;
            grant_q     <= grant_d;
            duty_q      <= duty_d;
        end
    end

    // Dwell expiry and owner drop on the same cycle collapse into one BLANK.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|req) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_SHOW;
            ST_SHOW:  if (dwell_cnt_q == DW_LAST || !owner_req) state_d = ST_BLANK;
            ST_BLANK: state_d = (|req) ? ST_LOAD : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        dwell_cnt_d = dwell_cnt_q;
        grant_d     = grant_q;
        duty_d      = duty_q;
        case (state_q)
            ST_IDLE, ST_BLANK: begin
                if (|req) win_d = pick_idx;
            end
            ST_LOAD: begin
                grant_d        = '0;
                grant_d[win_q] = 1'b1;
                rr_ptr_d       = (win_q == LAST_IDX) ? '0 : win_q + IDX_W'(1);
                dwell_cnt_d    = '0;
                duty_d         = load_duty;
            end
            ST_SHOW: begin
                if (state_d == ST_BLANK) begin
                    grant_d = '0;
                    duty_d  = '0;
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DW_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Duties reach the PWM only while SHOW continues, so the registered output
    // stays dark through LOAD and BLANK.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        pwm_duty = (state_d == ST_SHOW) ? duty_q : '0;
    end

    assign grant = grant_q;

    rgb_pwm_out #(
        .PWM_WIDTH (PWM_WIDTH)
    ) u_pwm (
        .clk  (clk),
        .rst  (rst),
        .duty (pwm_duty),
        .dout (dout)
    );

endmodule
